// File: rtl/adc_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// adc_pattern_gen_pkg
//   Shared definitions for the synthetic ADC pattern generator: register
//   offsets and bit positions, pattern-mode and FSM state enums, and the
//   LFSR seed and step function used by every sample lane.
// -----------------------------------------------------------------------------
package adc_pattern_gen_pkg;

  // Register window: six consecutive 32-bit words.
  localparam int unsigned NREGS = 6;

  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_LEN   = 3'd1;
  localparam logic [2:0] REG_STEP  = 3'd2;
  localparam logic [2:0] REG_CONST = 3'd3;
  localparam logic [2:0] REG_STAT  = 3'd4;
  localparam logic [2:0] REG_COUNT = 3'd5;

  // CTRL bits
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_CONT  = 4;

  // STAT bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  // Encoding 3 is an alias of ramp; it is stored as written so it reads back.
  typedef enum logic [1:0] {
    MODE_RAMP     = 2'd0,
    MODE_CONST    = 2'd1,
    MODE_LFSR     = 2'd2,
    MODE_RAMP_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Lane i is seeded with LFSR_SEED ^ i so lanes are distinguishable.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Right-shifting Fibonacci LFSR for x^16 + x^14 + x^13 + x^11 + 1.
  // In the shift-right form the taps 16/14/13/11 land on bits 0/2/3/5.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/adc_pattern_lane.sv
// -----------------------------------------------------------------------------
// adc_pattern_lane
//   One sample lane. Holds a ramp accumulator and a 16-bit LFSR; selects the
//   presented sample by mode. Both generators advance on every emitted sample
//   regardless of mode, so a mode switch mid-run continues from sample k.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   load_i        reload seeds (ramp = 0, LFSR = seed for this lane)
//   advance_i     a sample was emitted this cycle; step both generators
//   mode_i        pattern selection
//   step_i        ramp step (lane multiplies it by LANE+1)
//   const_i       constant-mode value
//   sample_o      sample presented this cycle
// -----------------------------------------------------------------------------
module adc_pattern_lane
  import adc_pattern_gen_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int LANE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             advance_i,
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] const_i,
  output logic [WIDTH-1:0] sample_o
);

  localparam logic [15:0]      SEED = LFSR_SEED ^ 16'(LANE);
  localparam logic [WIDTH-1:0] MULT = WIDTH'(LANE + 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      lfsr_stepped;

  // The LFSR sample for index k is the seed stepped k+1 times, so the lane
  // presents the already-stepped value and commits it when the sample is taken.
  assign lfsr_stepped = lfsr_next(lfsr_q);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_d  = acc_q;
    lfsr_d = lfsr_q;
    if (load_i) begin
      acc_d  = '0;
      lfsr_d = SEED;
    end else if (advance_i) begin
      acc_d  = acc_q + step_i * MULT;
      lfsr_d = lfsr_stepped;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      lfsr_q <= SEED;
    end else begin
      acc_q  <= acc_d;
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    sample_o = acc_q;
    unique case (mode_i)
      MODE_CONST: sample_o = const_i;
      MODE_LFSR:  sample_o = lfsr_stepped[WIDTH-1:0];
      default:    sample_o = acc_q;
    endcase
  end

endmodule

// File: rtl/adc_pattern_gen.sv
// -----------------------------------------------------------------------------
// adc_pattern_gen
//   Synthetic ADC source producing NCH WIDTH-bit lanes (ramp / constant / LFSR)
//   in bursts of LEN samples or continuously, configured over the register bus.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   bus_addr/wr/wdata/rd     word-addressed register bus, 1-cycle strobes
//   bus_rdata, bus_rvalid    read response, one cycle after bus_rd
//   ce                       sample enable; low stalls the generator
//   data_out                 lane i at [i*WIDTH +: WIDTH]
//   data_valid               data_out carries a new sample this cycle
//   busy                     generator is in ARM or RUN
//
// CNT_W must not exceed 32 (LEN and COUNT are read through 32-bit words).
// -----------------------------------------------------------------------------
module adc_pattern_gen
  import adc_pattern_gen_pkg::*;
#(
  parameter logic [31:0] BASEADDR = 32'h4000_0000 / 4,
  parameter int          NCH      = 2,
  parameter int          WIDTH    = 14,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          bus_addr,
  input  logic                 bus_wr,
  input  logic [31:0]          bus_wdata,
  input  logic                 bus_rd,
  output logic [31:0]          bus_rdata,
  output logic                 bus_rvalid,
  input  logic                 ce,
  output logic [NCH*WIDTH-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy
);

  // ---------------------------------------------------------------------------
  // Bus decode. Unsigned wrap makes addresses below BASEADDR fall outside too.
  // ---------------------------------------------------------------------------
  logic [31:0] addr_off;
  logic [2:0]  reg_sel;
  logic        in_win, wr_en, rd_en, wr_ctrl, wr_stat;
  logic        start_req, stop_req;

  assign addr_off  = bus_addr - BASEADDR;
  assign in_win    = (addr_off < 32'(NREGS));
  assign reg_sel   = addr_off[2:0];
  assign wr_en     = bus_wr && in_win;
  assign rd_en     = bus_rd && in_win;
  assign wr_ctrl   = wr_en && (reg_sel == REG_CTRL);
  assign wr_stat   = wr_en && (reg_sel == REG_STAT);
  // Stop takes priority when both bits arrive in one write.
  assign stop_req  = wr_ctrl && bus_wdata[CTRL_STOP];
  assign start_req = wr_ctrl && bus_wdata[CTRL_START] && !bus_wdata[CTRL_STOP];

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  mode_e             mode_q;
  logic              cont_q;
  logic [CNT_W-1:0]  len_q;
  logic [31:0]       step_q, const_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_RAMP;
      cont_q  <= 1'b0;
      len_q   <= '0;
      step_q  <= '0;
      const_q <= '0;
    end else if (wr_en) begin
      unique case (reg_sel)
        REG_CTRL: begin
          mode_q <= mode_e'(bus_wdata[3:2]);
          cont_q <= bus_wdata[CTRL_CONT];
        end
        REG_LEN:   len_q   <= CNT_W'(bus_wdata);
        REG_STEP:  step_q  <= bus_wdata;
        REG_CONST: const_q <= bus_wdata;
        default:   ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Lanes
  // ---------------------------------------------------------------------------
  state_e               state_q;
  logic                 emit;
  logic [NCH*WIDTH-1:0] lanes_packed;

  // data_valid follows ce in the same cycle so a stall is visible at once and
  // the first sample appears in the cycle after ARM.
  assign emit = (state_q == ST_RUN) && ce;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    adc_pattern_lane #(
      .WIDTH (WIDTH),
      .LANE  (i)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load_i    (state_q == ST_ARM),
      .advance_i (emit),
      .mode_i    (mode_q),
      .step_i    (step_q[WIDTH-1:0]),
      .const_i   (const_q[WIDTH-1:0]),
      .sample_o  (lanes_packed[i*WIDTH +: WIDTH])
    );
  end

  // ---------------------------------------------------------------------------
  // FSM, sample counter, done flag and held output
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W:0]       count_ext;
  logic                 last_sample;
  logic                 done_q;
  logic [NCH*WIDTH-1:0] hold_q;

  // Widened compare so a LEN lowered below COUNT mid-run still ends the burst.
  assign count_ext   = {1'b0, count_q} + (CNT_W+1)'(1);
  assign last_sample = (count_ext >= {1'b0, len_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      if (emit) begin
        count_q <= count_ext[CNT_W-1:0];
        hold_q  <= lanes_packed;
      end
      // A completing burst below overrides a same-cycle clear of done.
      if (wr_stat && bus_wdata[STAT_DONE]) done_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: if (start_req) state_q <= ST_ARM;
        ST_ARM: begin
          count_q <= '0;
          done_q  <= 1'b0;
          if (stop_req) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
          end else if (!cont_q && (len_q == '0)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop_req) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
          end else if (emit && !cont_q && last_sample) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign data_valid = emit;
  assign data_out   = emit ? lanes_packed : hold_q;

  // ---------------------------------------------------------------------------
  // Read path: response registered one cycle after the strobe; zero otherwise.
  // ---------------------------------------------------------------------------
  logic [31:0] rdata_d, rdata_q;
  logic        rvalid_q;

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      unique case (reg_sel)
        REG_CTRL:  rdata_d = {27'd0, cont_q, mode_q, 2'b00};
        REG_LEN:   rdata_d = 32'(len_q);
        REG_STEP:  rdata_d = step_q;
        REG_CONST: rdata_d = const_q;
        REG_STAT:  rdata_d = {30'd0, done_q, busy};
        REG_COUNT: rdata_d = 32'(count_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rd_en;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;

endmodule

// File: tb/tb_adc_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_adc_pattern_gen
//   Scoreboard bench for adc_pattern_gen (NCH=2, WIDTH=14). Stimulus pushes
//   expected samples and read data into queues; a negedge monitor pops and
//   compares whenever data_valid or bus_rvalid is presented.
// -----------------------------------------------------------------------------
module tb_adc_pattern_gen;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] O_CTRL = 0, O_LEN = 1, O_STEP = 2, O_CONST = 3,
                          O_STAT = 4, O_COUNT = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_addr = '0;
  logic        bus_wr = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic        bus_rd = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        ce = 1'b1;
  logic [27:0] data_out;
  logic        data_valid;
  logic        busy;

  adc_pattern_gen #(
    .BASEADDR (32'h4000_0000 / 4),
    .NCH      (2),
    .WIDTH    (14),
    .CNT_W    (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_addr   (bus_addr),
    .bus_wr     (bus_wr),
    .bus_wdata  (bus_wdata),
    .bus_rd     (bus_rd),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .ce         (ce),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [27:0] exp_q[$];
  logic [31:0] rd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] pack(input int l0, input int l1);
    return {14'(l1), 14'(l0)};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample: got 0x%0h expected no sample", data_out);
      end else begin
        check("sample", data_out, exp_q.pop_front());
      end
    end
    if (bus_rvalid === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got rdata 0x%0h expected no response", bus_rdata);
      end else begin
        check("rdata", bus_rdata, rd_q.pop_front());
      end
    end
  end

  // Watchdog
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_wr    = 1'b1;
    step();
    bus_wr    = 1'b0;
    bus_addr  = '0;
  endtask

  task automatic rd_expect(input logic [31:0] off, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus_addr = BASE + off;
    bus_rd   = 1'b1;
    step();
    bus_rd   = 1'b0;
    bus_addr = '0;
    @(negedge clk);
    check("rvalid", bus_rvalid, 1);
    step();
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (busy === 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    check(name, busy, 0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (3) step();
    @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", bus_rdata, 0);
    check("rst_rvalid", bus_rvalid, 0);
    step();
    reset = 1'b0;
    step();
    rd_expect(O_STAT, 0);
    rd_expect(O_COUNT, 0);

    // ---------------- burst ramp LEN=4 STEP=1 ----------------
    wr(BASE + O_LEN, 4);
    wr(BASE + O_STEP, 1);
    for (int k = 0; k < 4; k++) exp_q.push_back(pack(k, 2 * k));
    wr(BASE + O_CTRL, 32'h1);
    @(negedge clk);
    check("arm_busy", busy, 1);
    check("arm_valid", data_valid, 0);
    step();
    @(negedge clk);
    check("first_valid", data_valid, 1);
    repeat (3) step();
    @(negedge clk);
    check("busy_on_4th", busy, 1);
    step();
    @(negedge clk);
    check("burst_end_busy", busy, 0);
    check("burst_end_valid", data_valid, 0);
    check("burst_hold", data_out, pack(3, 6));
    step();
    rd_expect(O_STAT, 32'h2);
    rd_expect(O_COUNT, 4);

    // ---------------- ce stall 1,0,0,1 then stop ----------------
    wr(BASE + O_LEN, 10);
    wr(BASE + O_STEP, 5);
    exp_q.push_back(pack(0, 0));
    exp_q.push_back(pack(5, 10));
    wr(BASE + O_CTRL, 32'h1);
    step();
    ce = 1'b1; @(negedge clk); check("ce_v0", data_valid, 1); step();
    ce = 1'b0; @(negedge clk); check("ce_v1", data_valid, 0); check("ce_hold1", data_out, pack(0, 0)); step();
    ce = 1'b0; @(negedge clk); check("ce_v2", data_valid, 0); check("ce_hold2", data_out, pack(0, 0)); step();
    ce = 1'b1; @(negedge clk); check("ce_v3", data_valid, 1); step();
    ce = 1'b0;
    wr(BASE + O_CTRL, 32'h2);
    @(negedge clk);
    check("stop_data_out", data_out, 0);
    check("stop_busy", busy, 0);
    step();
    ce = 1'b1;
    rd_expect(O_COUNT, 2);
    rd_expect(O_STAT, 0);

    // ---------------- LFSR LEN=3 ----------------
    wr(BASE + O_LEN, 3);
    exp_q.push_back({14'h1670, 14'h1670});
    exp_q.push_back({14'h2B38, 14'h2B38});
    exp_q.push_back({14'h359C, 14'h159C});
    wr(BASE + O_CTRL, 32'h9);
    wait_idle("lfsr_idle", 20);
    rd_expect(O_STAT, 32'h2);
    rd_expect(O_COUNT, 3);
    rd_expect(O_CTRL, 32'h8);

    // ---------------- constant LEN=2 ----------------
    wr(BASE + O_LEN, 2);
    wr(BASE + O_CONST, 32'h12345);
    exp_q.push_back({14'h2345, 14'h2345});
    exp_q.push_back({14'h2345, 14'h2345});
    wr(BASE + O_CTRL, 32'h5);
    wait_idle("const_idle", 20);
    rd_expect(O_CONST, 32'h12345);

    // ---------------- mode 3 behaves as ramp ----------------
    wr(BASE + O_STEP, 3);
    exp_q.push_back(pack(0, 0));
    exp_q.push_back(pack(3, 6));
    wr(BASE + O_CTRL, 32'hD);
    wait_idle("mode3_idle", 20);
    rd_expect(O_CTRL, 32'hC);

    // ---------------- LEN=0, done clear, start+stop ----------------
    wr(BASE + O_LEN, 0);
    wr(BASE + O_CTRL, 32'h1);
    @(negedge clk);
    check("len0_arm_busy", busy, 1);
    check("len0_arm_valid", data_valid, 0);
    step();
    @(negedge clk);
    check("len0_idle_busy", busy, 0);
    step();
    rd_expect(O_STAT, 32'h2);
    wr(BASE + O_STAT, 32'h2);
    rd_expect(O_STAT, 0);
    wr(BASE + O_CTRL, 32'h3);
    @(negedge clk);
    check("startstop_busy0", busy, 0);
    step();
    @(negedge clk);
    check("startstop_busy1", busy, 0);
    step();

    // ---------------- out-of-window accesses ----------------
    bus_addr = BASE + 6; bus_rd = 1'b1; step(); bus_rd = 1'b0;
    @(negedge clk);
    check("oow6_rvalid", bus_rvalid, 0);
    check("oow6_rdata", bus_rdata, 0);
    step();
    bus_addr = BASE - 1; bus_rd = 1'b1; step(); bus_rd = 1'b0;
    @(negedge clk);
    check("oowm1_rvalid", bus_rvalid, 0);
    step();
    wr(BASE + 8, 32'h1);
    @(negedge clk);
    check("oow_start_busy", busy, 0);
    step();

    // ---------------- continuous ramp wrap, 16385 samples ----------------
    wr(BASE + O_STEP, 1);
    for (int k = 0; k < 16385; k++) exp_q.push_back(pack(k, 2 * k));
    wr(BASE + O_CTRL, 32'h11);
    repeat (16386) step();
    ce = 1'b0;
    rd_expect(O_STAT, 32'h1);
    rd_expect(O_COUNT, 16385);
    wr(BASE + O_CTRL, 32'h12);
    @(negedge clk);
    check("cont_stop_data_out", data_out, 0);
    check("cont_stop_busy", busy, 0);
    step();
    rd_expect(O_STAT, 0);
    ce = 1'b1;
    wr(BASE + O_CTRL, 32'h0);

    // ---------------- reset mid-run ----------------
    wr(BASE + O_LEN, 100);
    for (int k = 0; k < 3; k++) exp_q.push_back(pack(k, 2 * k));
    wr(BASE + O_CTRL, 32'h1);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("mrst_data_out", data_out, 0);
    check("mrst_valid", data_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_rvalid", bus_rvalid, 0);
    check("mrst_rdata", bus_rdata, 0);
    step();
    reset = 1'b0;
    step();
    rd_expect(O_STAT, 0);
    rd_expect(O_LEN, 0);
    rd_expect(O_STEP, 0);
    rd_expect(O_COUNT, 0);

    // ---------------- drain ----------------
    repeat (3) step();
    check("samples_left", exp_q.size(), 0);
    check("reads_left", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
